weight_ram_sched: RTL
=====================

# weight_ram_sched

Scheduler that owns the single port of one weight/bias `ram` instance and shares it between two requesters. The layer datapath requests read bursts, which stream a contiguous run of weights to the MAC pipeline. The weight-sync engine issues single-word writes when policy-net weights are copied into the target net. It sits between those requesters and the RAM macro, generating every enable, write-enable, address and write-data signal the RAM sees.

## Interface
- `DATA_WIDTH`, 32, weight word width.
- `ADDR_BITS`, 5, RAM address width; depth is 2^ADDR_BITS.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_start`  in  1  one-cycle burst request; accepted only while `rd_busy`=0.
- `rd_base`  in  ADDR_BITS  first address of burst; sampled on acceptance.
- `rd_len`  in  ADDR_BITS+1  number of words in the burst; sampled on acceptance.
- `rd_busy`  out  1  burst in progress, including the drain cycle.
- `rd_valid`  out  1  `rd_data` holds a burst word this cycle.
- `rd_data`  out  DATA_WIDTH  `ram_rdata` passed through.
- `rd_idx`  out  ADDR_BITS+1  index (0..len-1) of the word on `rd_data`.
- `rd_last`  out  1  final word of burst; high only together with `rd_valid`.
- `wr_req`  in  1  level write request; held with `wr_addr`/`wr_data` until acked.
- `wr_addr`  in  ADDR_BITS  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `wr_ack`  out  1  combinational; high in the cycle the write is accepted.
- `ram_en`, `ram_we`  out  1  registered RAM enables.
- `ram_addr`  out  ADDR_BITS  registered RAM address.
- `ram_wdata`  out  DATA_WIDTH  registered RAM write data.
- `ram_rdata`  in  DATA_WIDTH  RAM read data; valid 1 cycle after a read cycle (`ram_en`=1, `ram_we`=0).

## Operation
- FSM states:
  - IDLE: RAM free.
  - READ: issuing burst addresses.
  - DRAIN: waiting for the last read word.
- IDLE:
  - If `rd_start`=1 and `rd_len`≠0: latch base and len, clear the issue counter, go to READ. A read start has priority over `wr_req` in the same cycle, so `wr_ack`=0 that cycle.
  - If `rd_start`=1 and `rd_len`=0: ignore the start; no state change and no outputs.
  - Else if `wr_req`=1: `wr_ack`=1. The next cycle presents `ram_en`=1, `ram_we`=1, `ram_addr`=`wr_addr`, `ram_wdata`=`wr_data`. One write per cycle is sustained while `wr_req` stays high.
- READ:
  - Each cycle: `ram_en`=1, `ram_we`=0, `ram_addr`=(base+cnt) mod 2^ADDR_BITS, then cnt++.
  - After the len-th address, go to DRAIN.
- DRAIN: one cycle, then return to IDLE.
- `wr_ack`=0 in READ and DRAIN; pending writes wait.
- `rd_start` while `rd_busy`=1 is ignored, not queued.
- Read return path:
  - `rd_valid` and `rd_idx` are a 1-cycle registered delay of the "issuing read" flag and of cnt.
  - `rd_last` = `rd_valid` && `rd_idx`=len-1.
- Address wrap: a burst crossing the top of the RAM continues at address 0. When len > 2^ADDR_BITS, addresses repeat modulo the depth and every word is still delivered.
- Reset (any state, including mid-burst): state IDLE; all outputs 0, including `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `rd_valid`, `rd_idx`, `rd_last`, `rd_busy`. Counters and latched base/len are cleared. In-flight read data is discarded: `rd_valid` stays 0 in the cycle after reset.

## Timing
- Burst accepted at cycle T:
  - T+1..T+len: `ram_en`=1, addresses issued.
  - T+2..T+len+1: `rd_valid`=1, data returned.
  - `rd_last` at T+len+1.
  - `rd_busy`=1 from T+1 through T+len+1; `rd_busy`=0 at T+len+2.
- Next `rd_start` is accepted at T+len+2 at the earliest.
- Write acked at cycle W: RAM write at W+1.
- After a burst, a held `wr_req` is acked at T+len+2.
- Throughput: 1 word/cycle for both reads and writes; 1 idle turnaround cycle (DRAIN) after every burst.

## Test plan
- Preload RAM[i]=i. `rd_start`, base=3, len=4 → `ram_addr` 3,4,5,6 at T+1..T+4; `rd_data` 3,4,5,6 with `rd_idx` 0..3 at T+2..T+5; `rd_last` only at T+5; `rd_busy` low at T+6.
- Wrap: base=30, len=4, ADDR_BITS=5 → addresses 30,31,0,1; 4 valid words; `rd_last` on the word from address 1.
- Arbitration: `rd_start` (len=2) and `wr_req` (addr=7, data=0xDEADBEEF) asserted in the same cycle → `wr_ack`=0 throughout the burst. `wr_ack`=1 at T+4, RAM write at T+5; a later read of address 7 returns 0xDEADBEEF.
- Back-to-back writes: `wr_req` held for 3 cycles with addresses 0,1,2 → `wr_ack` high 3 consecutive cycles; 3 consecutive RAM write cycles with matching data.
- Degenerate and illegal starts: `rd_start` with len=0 → `rd_busy`, `ram_en`, `rd_valid` all stay 0. `rd_start` mid-burst → ignored; exactly len words delivered.
- Reset mid-burst: base=0, len=8, `rst` asserted at T+3 → all outputs 0 the following cycle, no `rd_valid` afterwards, FSM in IDLE. A new burst is accepted on the first cycle after reset is released.

Source files
------------

// File: rtl/weight_ram_sched_if.sv
// Bundle of requester-side and RAM-side signals owned by weight_ram_sched.
// The slave modport is the scheduler view; the master modport is the environment view.
interface weight_ram_sched_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_BITS  = 5
);
   logic                  rd_start;
   logic [ADDR_BITS-1:0]  rd_base;
   logic [ADDR_BITS:0]    rd_len;
   logic                  rd_busy;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_BITS:0]    rd_idx;
   logic                  rd_last;

   logic                  wr_req;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ack;

   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_BITS-1:0]  ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  rd_start, rd_base, rd_len, wr_req, wr_addr, wr_data, ram_rdata,
      output rd_busy, rd_valid, rd_data, rd_idx, rd_last, wr_ack,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output rd_start, rd_base, rd_len, wr_req, wr_addr, wr_data, ram_rdata,
      input  rd_busy, rd_valid, rd_data, rd_idx, rd_last, wr_ack,
             ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/weight_ram_sched.sv
// Single-port weight RAM scheduler: read bursts for the layer datapath, single-word
// writes for the weight-sync engine, with bursts taking priority.
module weight_ram_sched #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_BITS  = 5
) (
   input logic                clk,
   input logic                rst,
   weight_ram_sched_if.slave  bus_io
);
   localparam int unsigned CntW = ADDR_BITS + 1;

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e                state_q, state_d;
   logic [ADDR_BITS-1:0]  base_q, base_d;
   logic [CntW-1:0]       len_q, len_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_BITS-1:0]  ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic [CntW-1:0]       ram_idx_q, ram_idx_d;
   logic                  rd_valid_q;
   logic [CntW-1:0]       rd_idx_q;
   logic                  wr_ack;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_idx_d   = ram_idx_q;
      wr_ack      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.rd_start && (bus_io.rd_len != '0)) begin
               // Word 0 is issued straight from the request, so the counter restarts at 1.
               base_d     = bus_io.rd_base;
               len_d      = bus_io.rd_len;
               cnt_d      = CntW'(1);
               ram_en_d   = 1'b1;
               ram_addr_d = bus_io.rd_base;
               ram_idx_d  = '0;
               state_d    = StRead;
            end else if (!bus_io.rd_start && bus_io.wr_req) begin
               wr_ack      = 1'b1;
               ram_en_d    = 1'b1;
               ram_we_d    = 1'b1;
               ram_addr_d  = bus_io.wr_addr;
               ram_wdata_d = bus_io.wr_data;
            end
         end
         StRead: begin
            if (cnt_q != len_q) begin
               ram_en_d   = 1'b1;
               ram_addr_d = base_q + ADDR_BITS'(cnt_q);
               ram_idx_d  = cnt_q;
               cnt_d      = cnt_q + CntW'(1);
            end else begin
               state_d = StDrain;
            end
         end
         StDrain: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         base_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_idx_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_idx_q    <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_idx_q   <= ram_idx_d;
         rd_valid_q  <= ram_en_q & ~ram_we_q;
         rd_idx_q    <= ram_idx_q;
      end
   end

   assign bus_io.ram_en    = ram_en_q;
   assign bus_io.ram_we    = ram_we_q;
   assign bus_io.ram_addr  = ram_addr_q;
   assign bus_io.ram_wdata = ram_wdata_q;
   assign bus_io.rd_busy   = (state_q != StIdle);
   assign bus_io.rd_valid  = rd_valid_q;
   assign bus_io.rd_idx    = rd_idx_q;
   assign bus_io.rd_data   = bus_io.ram_rdata;
   assign bus_io.rd_last   = rd_valid_q && (rd_idx_q == (len_q - CntW'(1)));
   assign bus_io.wr_ack    = wr_ack & ~rst;
endmodule
